// File: rtl/x_axis_speed_controller.sv
// rtl/x_axis_speed_controller.sv - X-axis scanner motor speed loop: feedback period measurement, duty trim, lock/stall status, PWM drive
module x_axis_speed_controller #(
  parameter int PWM_BITS    = 10,
  parameter int CNT_BITS    = 24,
  parameter int DUTY_STEP   = 4,
  parameter int TOL         = 256,
  parameter int LOCK_COUNT  = 8,
  parameter int SPINUP_DUTY = 768
) (
  input  logic                clk_50,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] target_period,
  input  logic                feedback_clk,
  output logic                motor_ctrl_signal,
  output logic [PWM_BITS-1:0] duty,
  output logic [CNT_BITS-1:0] measured_period,
  output logic                period_valid,
  output logic                locked,
  output logic                stalled,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int                   IC_BITS  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0]  PWM_MAX  = '1;
  localparam logic [PWM_BITS-1:0]  SPIN     = PWM_BITS'(SPINUP_DUTY);
  localparam logic [PWM_BITS:0]    STEP     = (PWM_BITS + 1)'(DUTY_STEP);
  localparam logic [CNT_BITS:0]    TOL_W    = (CNT_BITS + 1)'(TOL);
  localparam logic [IC_BITS-1:0]   LOCK_N   = IC_BITS'(LOCK_COUNT);
  localparam logic [IC_BITS-1:0]   IC_ONE   = IC_BITS'(1);

  state_t cur_state, nxt_state;

  logic fb_s1, fb_s2, fb_s3;
  logic fb_edge;

  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic                have_edge, have_edge_n;
  logic [IC_BITS-1:0]  inrange_cnt, inrange_cnt_n;
  logic [PWM_BITS-1:0] duty_n;
  logic                locked_n, stalled_n;
  logic [CNT_BITS-1:0] measured_n;
  logic                period_valid_n;

  logic [PWM_BITS:0]   duty_sum;
  logic [PWM_BITS-1:0] duty_up, duty_dn;
  logic [IC_BITS-1:0]  inrange_inc;
  logic                slow, fast, in_range, stall_hit;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_act;

  // Two synchronizer flops plus a history flop for rising-edge detection.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      fb_s1 <= 1'b0;
      fb_s2 <= 1'b0;
      fb_s3 <= 1'b0;
    end else begin
      fb_s1 <= feedback_clk;
      fb_s2 <= fb_s1;
      fb_s3 <= fb_s2;
    end
  end

  assign fb_edge = fb_s2 & ~fb_s3;

  // Widened compare keeps target+TOL and measured+TOL from wrapping.
  always_comb begin
    slow     = {1'b0, measured_period} > ({1'b0, target_period} + TOL_W);
    fast     = ({1'b0, measured_period} + TOL_W) < {1'b0, target_period};
    in_range = !slow && !fast;
  end

  always_comb begin
    duty_sum    = {1'b0, duty} + STEP;
    duty_up     = duty_sum[PWM_BITS] ? PWM_MAX : duty_sum[PWM_BITS-1:0];
    duty_dn     = ({1'b0, duty} < STEP) ? '0 : (duty - STEP[PWM_BITS-1:0]);
    inrange_inc = inrange_cnt + IC_ONE;
    stall_hit   = (cnt == (CNT_MAX - 1'b1)) && !fb_edge;
  end

  always_comb begin
    nxt_state      = cur_state;
    cnt_n          = cnt;
    have_edge_n    = have_edge;
    inrange_cnt_n  = inrange_cnt;
    duty_n         = duty;
    locked_n       = locked;
    stalled_n      = stalled;
    measured_n     = measured_period;
    period_valid_n = 1'b0;

    if (!enable) begin
      nxt_state     = ST_IDLE;
      cnt_n         = '0;
      have_edge_n   = 1'b0;
      inrange_cnt_n = '0;
      duty_n        = '0;
      locked_n      = 1'b0;
      stalled_n     = 1'b0;
    end else if (cur_state == ST_IDLE) begin
      nxt_state = ST_SPINUP;
      duty_n    = SPIN;
      cnt_n     = '0;
    end else begin
      if (fb_edge) begin
        measured_n     = cnt;
        cnt_n          = {{(CNT_BITS-1){1'b0}}, 1'b1};
        have_edge_n    = 1'b1;
        period_valid_n = have_edge && (cnt != CNT_MAX);
      end else if (cnt != CNT_MAX) begin
        cnt_n = cnt + 1'b1;
      end

      // A stall forgets the previous edge so the next edge only re-arms timing.
      if (stall_hit) begin
        stalled_n     = 1'b1;
        locked_n      = 1'b0;
        have_edge_n   = 1'b0;
        inrange_cnt_n = '0;
        nxt_state     = ST_SPINUP;
        duty_n        = SPIN;
      end else if (period_valid) begin
        stalled_n = 1'b0;
        case (cur_state)
          ST_SPINUP: begin
            if (!slow) begin
              nxt_state     = ST_TRACK;
              inrange_cnt_n = in_range ? IC_ONE : '0;
            end
          end
          ST_TRACK: begin
            if (slow) begin
              duty_n        = duty_up;
              inrange_cnt_n = '0;
            end else if (fast) begin
              duty_n        = duty_dn;
              inrange_cnt_n = '0;
            end else begin
              inrange_cnt_n = inrange_inc;
              if (inrange_inc == LOCK_N) begin
                nxt_state = ST_LOCKED;
                locked_n  = 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (!in_range) begin
              duty_n        = slow ? duty_up : duty_dn;
              nxt_state     = ST_TRACK;
              locked_n      = 1'b0;
              inrange_cnt_n = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_state       <= ST_IDLE;
      cnt             <= '0;
      have_edge       <= 1'b0;
      inrange_cnt     <= '0;
      duty            <= '0;
      locked          <= 1'b0;
      stalled         <= 1'b0;
      measured_period <= '0;
      period_valid    <= 1'b0;
    end else begin
      cur_state       <= nxt_state;
      cnt             <= cnt_n;
      have_edge       <= have_edge_n;
      inrange_cnt     <= inrange_cnt_n;
      duty            <= duty_n;
      locked          <= locked_n;
      stalled         <= stalled_n;
      measured_period <= measured_n;
      period_valid    <= period_valid_n;
    end
  end

  assign state = cur_state;

  // duty_act only reloads at the end of a PWM period so pulses never get cut short.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt           <= '0;
      duty_act          <= '0;
      motor_ctrl_signal <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == PWM_MAX) begin
        duty_act <= duty;
      end
      motor_ctrl_signal <= (nxt_state != ST_IDLE) && (pwm_cnt < duty_act);
    end
  end

endmodule

// File: tb/tb_x_axis_speed_controller.sv
// tb/tb_x_axis_speed_controller.sv - scoreboard bench for x_axis_speed_controller with a reference model of the speed loop
module tb_x_axis_speed_controller;

  localparam int PB   = 6;
  localparam int CB   = 10;
  localparam int STP  = 4;
  localparam int TOLV = 16;
  localparam int LC   = 4;
  localparam int SD   = 48;
  localparam int TGT  = 300;
  localparam int DMAX = (1 << PB) - 1;

  logic          clk_50 = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [CB-1:0] target_period;
  logic          feedback_clk;
  logic          motor_ctrl_signal;
  logic [PB-1:0] duty;
  logic [CB-1:0] measured_period;
  logic          period_valid;
  logic          locked;
  logic          stalled;
  logic [1:0]    state;

  x_axis_speed_controller #(
    .PWM_BITS(PB), .CNT_BITS(CB), .DUTY_STEP(STP), .TOL(TOLV),
    .LOCK_COUNT(LC), .SPINUP_DUTY(SD)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .enable(enable),
    .target_period(target_period), .feedback_clk(feedback_clk),
    .motor_ctrl_signal(motor_ctrl_signal), .duty(duty),
    .measured_period(measured_period), .period_valid(period_valid),
    .locked(locked), .stalled(stalled), .state(state)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct {
    int meas;
    int st;
    int dty;
    int lk;
  } exp_t;

  exp_t q[$];
  exp_t post_exp;
  bit   post_pend = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model of the loop at the level of measured intervals.
  int m_st, m_duty, m_lk, m_have, m_ic, last_p;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_duty = 0; m_lk = 0; m_have = 0; m_ic = 0; last_p = 0;
  endtask

  task automatic model_pv(input int p);
    bit   is_slow, is_fast;
    exp_t e;
    is_slow = (p > TGT + TOLV);
    is_fast = (p + TOLV < TGT);
    case (m_st)
      1: if (!is_slow) begin m_st = 2; m_ic = is_fast ? 0 : 1; end
      2: begin
        if (is_slow) begin m_duty = (m_duty + STP > DMAX) ? DMAX : m_duty + STP; m_ic = 0; end
        else if (is_fast) begin m_duty = (m_duty < STP) ? 0 : m_duty - STP; m_ic = 0; end
        else begin
          m_ic++;
          if (m_ic == LC) begin m_st = 3; m_lk = 1; end
        end
      end
      3: if (is_slow || is_fast) begin
        m_duty = is_slow ? ((m_duty + STP > DMAX) ? DMAX : m_duty + STP)
                         : ((m_duty < STP) ? 0 : m_duty - STP);
        m_st = 2; m_lk = 0; m_ic = 0;
      end
      default: ;
    endcase
    e.meas = p; e.st = m_st; e.dty = m_duty; e.lk = m_lk;
    q.push_back(e);
  endtask

  // Rising feedback edge, then p cycles until the next one; long gaps stall the loop.
  task automatic rise(input int p);
    int highs;
    if (m_have != 0) model_pv(last_p);
    m_have = 1;
    feedback_clk = 1'b1;
    repeat (3) @(negedge clk_50);
    feedback_clk = 1'b0;
    if (p >= 160) begin
      repeat (80) @(negedge clk_50);
      highs = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk_50);
        highs += int'(motor_ctrl_signal);
      end
      chk("pwm_high_count", highs, m_duty);
      repeat (p - 3 - 80 - 64) @(negedge clk_50);
    end else begin
      repeat (p - 3) @(negedge clk_50);
    end
    last_p = p;
    if (p >= 1100) begin
      m_st = 1; m_duty = SD; m_lk = 0; m_have = 0; m_ic = 0;
      chk("stall_state", int'(state), 1);
      chk("stall_flag", int'(stalled), 1);
      chk("stall_locked", int'(locked), 0);
      chk("stall_duty", int'(duty), SD);
    end
  endtask

  function automatic int rand_period();
    case ($urandom_range(0, 5))
      0: return TGT;
      1: return TGT - TOLV + int'($urandom_range(0, 2 * TOLV));
      2: return TGT + TOLV + 1 + int'($urandom_range(0, 60));
      3: return 200 + int'($urandom_range(0, TGT - TOLV - 1 - 200));
      4: return TGT + TOLV;
      default: return TGT - TOLV;
    endcase
  endfunction

  always @(negedge clk_50) begin
    if (post_pend) begin
      chk("post_state", int'(state), post_exp.st);
      chk("post_duty", int'(duty), post_exp.dty);
      chk("post_locked", int'(locked), post_exp.lk);
      chk("post_stalled", int'(stalled), 0);
      post_pend = 1'b0;
    end
    if (period_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_period_valid", 1, 0);
      end else begin
        post_exp = q.pop_front();
        chk("measured_period", int'(measured_period), post_exp.meas);
        post_pend = 1'b1;
      end
    end
  end

  initial begin
    int bad;
    model_reset();
    reset_n = 1'b0; enable = 1'b0; feedback_clk = 1'b0;
    target_period = CB'(TGT);
    repeat (5) @(negedge clk_50);
    chk("rst_state", int'(state), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_motor", int'(motor_ctrl_signal), 0);
    chk("rst_measured", int'(measured_period), 0);
    chk("rst_flags", int'({period_valid, locked, stalled}), 0);

    reset_n = 1'b1;
    repeat (3) @(negedge clk_50);
    enable = 1'b1;
    @(negedge clk_50);
    m_st = 1; m_duty = SD;
    chk("spinup_state", int'(state), 1);
    chk("spinup_duty", int'(duty), SD);

    repeat (7) rise(TGT);
    rise(TGT + TOLV);
    repeat (6) rise(TGT + TOLV + 1);
    repeat (16) rise(TGT - TOLV - 1);
    rise(TGT - TOLV);
    repeat (40) rise(rand_period());

    repeat (7) rise(TGT);
    rise(1100);
    repeat (3) rise(TGT);

    repeat (6) rise(TGT);
    chk("pre_drop_state", int'(state), m_st);
    feedback_clk = 1'b1;
    repeat (2) @(negedge clk_50);
    enable = 1'b0;
    @(negedge clk_50);
    model_reset();
    chk("drop_state", int'(state), 0);
    chk("drop_duty", int'(duty), 0);
    chk("drop_motor", int'(motor_ctrl_signal), 0);
    chk("drop_pv", int'(period_valid), 0);
    chk("drop_locked", int'(locked), 0);
    feedback_clk = 1'b0;
    repeat (20) @(negedge clk_50);

    enable = 1'b1;
    @(negedge clk_50);
    m_st = 1; m_duty = SD;
    repeat (10) rise(rand_period());

    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_duty", int'(duty), 0);
    chk("async_rst_motor", int'(motor_ctrl_signal), 0);
    chk("async_rst_flags", int'({period_valid, locked, stalled}), 0);
    q.delete();
    model_reset();
    repeat (3) @(negedge clk_50);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50);
      if (state != 2'd0 || motor_ctrl_signal != 1'b0) bad++;
    end
    chk("idle_hold_after_reset", bad, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
